sc_point_row_sequencer: RTL and testbench
=========================================

SC_POINT_ROW_SEQUENCER -- requirements
Module: sc_point_row_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SC_POINT_ROW_SEQUENCER_CLOCK_50 and SC_POINT_ROW_SEQUENCER_RESET_InLow.
REQ-002 The block SHALL take these parameters (name, default, meaning):
  - SHIFT_PERIOD, 16, base clock cycles between shifts.
  - PERIOD_WIDTH, 24, width of the period counter.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
  - SC_POINT_ROW_SEQUENCER_CLOCK_50  in  1  system clock.
  - SC_POINT_ROW_SEQUENCER_RESET_InLow  in  1  async reset, active low.
  - SC_POINT_ROW_SEQUENCER_start_InLow  in  1  start/restart game.
  - SC_POINT_ROW_SEQUENCER_direction_In  in  1  0 = rotate left, 1 = rotate right.
  - SC_POINT_ROW_SEQUENCER_collision_In  in  1  frog hit the row.
  - SC_POINT_ROW_SEQUENCER_levelup_In  in  1  frog reached the goal.
  - SC_POINT_ROW_SEQUENCER_clear_OutLow  out  1  row register clear command.
  - SC_POINT_ROW_SEQUENCER_load0_OutLow  out  1  load initial pattern.
  - SC_POINT_ROW_SEQUENCER_load1_OutLow  out  1  load next-level pattern.
  - SC_POINT_ROW_SEQUENCER_shiftselection_Out  out  2  01 = left, 10 = right, 00 = hold.
  - SC_POINT_ROW_SEQUENCER_clearLOST_OutLow  out  1  blank the row on a loss.
  - SC_POINT_ROW_SEQUENCER_level_OutBUS  out  3  current level.
  - SC_POINT_ROW_SEQUENCER_lives_OutBUS  out  2  remaining lives.
  - SC_POINT_ROW_SEQUENCER_gameover_Out  out  1  high while in GAMEOVER.

Function
REQ-004 FSM states SHALL be IDLE, CLEAR, LOAD0, RUN, SHIFT, LOST, LOAD1 and GAMEOVER; all outputs SHALL be registered.
REQ-005 At most one row command (clear, load0, load1, shift, clearLOST) SHALL be active in any cycle; each command SHALL last exactly one cycle.
REQ-006 Default command outputs SHALL be: every _OutLow high, shiftselection 00.
REQ-007 IDLE -> CLEAR when start_InLow is sampled low; CLEAR -> LOAD0 -> RUN unconditionally; the command SHALL appear on the cycle after the state is entered.
REQ-008 In RUN the period counter SHALL increment each cycle. Effective period P = max(1, SHIFT_PERIOD >> level). When counter == P-1: counter -> 0, state -> SHIFT.
REQ-009 SHIFT SHALL drive shiftselection = direction_In ? 10 : 01 for one cycle, then return to RUN.
REQ-010 RUN priority SHALL be collision_In > levelup_In > period expiry; simultaneous events SHALL honour only the highest and discard the rest; the counter SHALL clear on leaving RUN for LOST or LOAD1.
REQ-011 LOST SHALL pulse clearLOST low and decrement lives; next state SHALL be LOAD0 if the decremented lives > 0, else GAMEOVER.
REQ-012 LOAD1 SHALL pulse load1 low, increment level (saturating at 7), then return to RUN.
REQ-013 GAMEOVER SHALL hold gameover_Out high and all commands inactive; start_InLow low SHALL go to CLEAR with lives reloaded to 3 and level 0.
REQ-014 start_InLow low in any state other than IDLE/GAMEOVER SHALL be ignored.
REQ-015 collision_In and levelup_In SHALL be ignored outside RUN.

Reset
REQ-016 Reset assertion SHALL immediately force state IDLE, counter 0, lives 3, level 0, gameover 0, all commands inactive, including when a command is active.
REQ-017 After reset deassertion the FSM SHALL remain in IDLE until start_InLow is sampled low.

Configuration
REQ-018 With SC_POINT_ROW_SEQUENCER_LIVES_EN defined, lives SHALL behave as in REQ-011/013.
REQ-019 Without SC_POINT_ROW_SEQUENCER_LIVES_EN, lives_OutBUS SHALL be tied to 0 and LOST SHALL always go to GAMEOVER.

Structure
REQ-020 A shared package SHALL hold the state encoding, the shiftselection codes (HOLD = 00, LEFT = 01, RIGHT = 10) and INIT_LIVES = 3.
REQ-021 The period counter with compare SHALL be one sub-module, sc_point_period_counter (inputs: enable, clear, period; output: expire).

Verification
REQ-022 Reset, start low one cycle -> clear pulse, then load0 pulse on the next cycle, then RUN.
REQ-023 SHIFT_PERIOD = 8, level 0, direction 0 -> shiftselection = 01 exactly once every 9 cycles (8 RUN + 1 SHIFT).
REQ-024 collision and levelup high in the same RUN cycle -> only clearLOST pulses; lives 3 -> 2; load0 follows.
REQ-025 Three collisions -> lives reach 0 and gameover_Out = 1; start low -> lives = 3, level = 0, clear pulses.
REQ-026 levelup at level 2 with SHIFT_PERIOD = 8 -> load1 pulse, level = 3, shift period becomes 1, i.e. a shift on every RUN cycle.
REQ-027 Reset asserted during the SHIFT cycle -> shiftselection = 00 in the same cycle, state IDLE.

Source files
------------

// File: rtl/sc_point_row_sequencer_pkg.sv
// Shared definitions for the point-row sequencer: state encoding, shift codes,
// row command bundle and life/level limits.
package sc_point_row_sequencer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_LOAD0    = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_SHIFT    = 3'd4;
    localparam logic [2:0] ST_LOST     = 3'd5;
    localparam logic [2:0] ST_LOAD1    = 3'd6;
    localparam logic [2:0] ST_GAMEOVER = 3'd7;

    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    localparam logic [1:0] INIT_LIVES = 2'd3;
    localparam logic [2:0] MAX_LEVEL  = 3'd7;

    typedef struct packed {
        logic       clearN;
        logic       load0N;
        logic       load1N;
        logic       clearLostN;
        logic [1:0] shiftSel;
    } rowCmd_t;

    function automatic rowCmd_t cmdIdle();
        rowCmd_t c;
        c.clearN     = 1'b1;
        c.load0N     = 1'b1;
        c.load1N     = 1'b1;
        c.clearLostN = 1'b1;
        c.shiftSel   = SHIFT_HOLD;
        return c;
    endfunction

endpackage

// File: rtl/sc_point_period_counter.sv
// Shift-period timer: counts enabled cycles and flags the last cycle of each period.
module sc_point_period_counter #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    SC_POINT_PERIOD_COUNTER_CLOCK_50,
    input  logic                    SC_POINT_PERIOD_COUNTER_RESET_InLow,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    expire
);

    logic [PERIOD_WIDTH-1:0] count;

    // >= rather than == so a shrinking period can never strand the count above it
    assign expire = enable && (count >= (period - PERIOD_WIDTH'(1)));

    always_ff @(posedge SC_POINT_PERIOD_COUNTER_CLOCK_50 or negedge SC_POINT_PERIOD_COUNTER_RESET_InLow) begin
        if (!SC_POINT_PERIOD_COUNTER_RESET_InLow) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_point_row_sequencer.sv
// Point-row game sequencer: drives row register commands, tracks level and lives.
// Optional macro SC_POINT_ROW_SEQUENCER_LIVES_EN enables the lives counter.
module sc_point_row_sequencer
    import sc_point_row_sequencer_pkg::*;
#(
    parameter int SHIFT_PERIOD = 16,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic       SC_POINT_ROW_SEQUENCER_CLOCK_50,
    input  logic       SC_POINT_ROW_SEQUENCER_RESET_InLow,
    input  logic       SC_POINT_ROW_SEQUENCER_start_InLow,
    input  logic       SC_POINT_ROW_SEQUENCER_direction_In,
    input  logic       SC_POINT_ROW_SEQUENCER_collision_In,
    input  logic       SC_POINT_ROW_SEQUENCER_levelup_In,
    output logic       SC_POINT_ROW_SEQUENCER_clear_OutLow,
    output logic       SC_POINT_ROW_SEQUENCER_load0_OutLow,
    output logic       SC_POINT_ROW_SEQUENCER_load1_OutLow,
    output logic [1:0] SC_POINT_ROW_SEQUENCER_shiftselection_Out,
    output logic       SC_POINT_ROW_SEQUENCER_clearLOST_OutLow,
    output logic [2:0] SC_POINT_ROW_SEQUENCER_level_OutBUS,
    output logic [1:0] SC_POINT_ROW_SEQUENCER_lives_OutBUS,
    output logic       SC_POINT_ROW_SEQUENCER_gameover_Out
);

    logic [2:0]              state;
    logic [2:0]              stateNext;
    logic [2:0]              level;
    rowCmd_t                 cmdQ;
    rowCmd_t                 cmdNext;
    logic                    gameoverQ;
    logic                    runActive;
    logic                    runAbort;
    logic                    expire;
    logic                    lastLife;
    logic                    startReq;
    logic [PERIOD_WIDTH-1:0] periodShifted;
    logic [PERIOD_WIDTH-1:0] period;

    assign startReq  = !SC_POINT_ROW_SEQUENCER_start_InLow;
    assign runActive = (state == ST_RUN);
    assign runAbort  = runActive && (SC_POINT_ROW_SEQUENCER_collision_In || SC_POINT_ROW_SEQUENCER_levelup_In);

    // Each level halves the shift period, never below one cycle
    assign periodShifted = PERIOD_WIDTH'(SHIFT_PERIOD) >> level;
    assign period        = (periodShifted == '0) ? PERIOD_WIDTH'(1) : periodShifted;

    sc_point_period_counter #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) uPeriodCounter (
        .SC_POINT_PERIOD_COUNTER_CLOCK_50   (SC_POINT_ROW_SEQUENCER_CLOCK_50),
        .SC_POINT_PERIOD_COUNTER_RESET_InLow(SC_POINT_ROW_SEQUENCER_RESET_InLow),
        .enable                             (runActive),
        .clear                              (runAbort),
        .period                             (period),
        .expire                             (expire)
    );

`ifdef SC_POINT_ROW_SEQUENCER_LIVES_EN
    logic [1:0] lives;

    assign lastLife = (lives <= 2'd1);

    always_ff @(posedge SC_POINT_ROW_SEQUENCER_CLOCK_50 or negedge SC_POINT_ROW_SEQUENCER_RESET_InLow) begin
        if (!SC_POINT_ROW_SEQUENCER_RESET_InLow) begin
            lives <= INIT_LIVES;
        end else if (state == ST_LOST) begin
            lives <= lives - 2'd1;
        end else if ((state == ST_GAMEOVER) && startReq) begin
            lives <= INIT_LIVES;
        end
    end

    assign SC_POINT_ROW_SEQUENCER_lives_OutBUS = lives;
`else
    assign lastLife = 1'b1;
    assign SC_POINT_ROW_SEQUENCER_lives_OutBUS = 2'b00;
`endif

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:     if (startReq) stateNext = ST_CLEAR;
            ST_CLEAR:    stateNext = ST_LOAD0;
            ST_LOAD0:    stateNext = ST_RUN;
            ST_RUN: begin
                if (SC_POINT_ROW_SEQUENCER_collision_In)     stateNext = ST_LOST;
                else if (SC_POINT_ROW_SEQUENCER_levelup_In)  stateNext = ST_LOAD1;
                else if (expire)                             stateNext = ST_SHIFT;
            end
            ST_SHIFT:    stateNext = ST_RUN;
            ST_LOST:     stateNext = lastLife ? ST_GAMEOVER : ST_LOAD0;
            ST_LOAD1:    stateNext = ST_RUN;
            ST_GAMEOVER: if (startReq) stateNext = ST_CLEAR;
            default:     stateNext = ST_IDLE;
        endcase
    end

    // Commands are decoded from the current state and registered, so each one
    // shows up on the cycle after its state is entered and lasts one cycle.
    always_comb begin
        cmdNext = cmdIdle();
        case (state)
            ST_CLEAR: cmdNext.clearN     = 1'b0;
            ST_LOAD0: cmdNext.load0N     = 1'b0;
            ST_LOAD1: cmdNext.load1N     = 1'b0;
            ST_LOST:  cmdNext.clearLostN = 1'b0;
            ST_SHIFT: cmdNext.shiftSel   = SC_POINT_ROW_SEQUENCER_direction_In ? SHIFT_RIGHT : SHIFT_LEFT;
            default:  cmdNext = cmdIdle();
        endcase
    end

    always_ff @(posedge SC_POINT_ROW_SEQUENCER_CLOCK_50 or negedge SC_POINT_ROW_SEQUENCER_RESET_InLow) begin
        if (!SC_POINT_ROW_SEQUENCER_RESET_InLow) begin
            state     <= ST_IDLE;
            level     <= 3'd0;
            cmdQ      <= cmdIdle();
            gameoverQ <= 1'b0;
        end else begin
            state     <= stateNext;
            cmdQ      <= cmdNext;
            gameoverQ <= (state == ST_GAMEOVER);
            if ((state == ST_LOAD1) && (level != MAX_LEVEL)) begin
                level <= level + 3'd1;
            end else if ((state == ST_GAMEOVER) && startReq) begin
                level <= 3'd0;
            end
        end
    end

    assign SC_POINT_ROW_SEQUENCER_clear_OutLow       = cmdQ.clearN;
    assign SC_POINT_ROW_SEQUENCER_load0_OutLow       = cmdQ.load0N;
    assign SC_POINT_ROW_SEQUENCER_load1_OutLow       = cmdQ.load1N;
    assign SC_POINT_ROW_SEQUENCER_clearLOST_OutLow   = cmdQ.clearLostN;
    assign SC_POINT_ROW_SEQUENCER_shiftselection_Out = cmdQ.shiftSel;
    assign SC_POINT_ROW_SEQUENCER_level_OutBUS       = level;
    assign SC_POINT_ROW_SEQUENCER_gameover_Out       = gameoverQ;

endmodule

// File: tb/tb_sc_point_row_sequencer.sv
// Bench for sc_point_row_sequencer: directed game scenarios plus random play
// against a game-level reference model.
module tb_sc_point_row_sequencer;

    localparam int SP = 8;
`ifdef SC_POINT_ROW_SEQUENCER_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_n = 1'b1;
    logic dir = 1'b0;
    logic col = 1'b0;
    logic lvl = 1'b0;

    logic       clear_n, load0_n, load1_n, clear_lost_n, gameover;
    logic [1:0] shift_sel, lives_o;
    logic [2:0] level_o;

    always #5 clk = ~clk;

    sc_point_row_sequencer #(
        .SHIFT_PERIOD(SP),
        .PERIOD_WIDTH(24)
    ) dut (
        .SC_POINT_ROW_SEQUENCER_CLOCK_50          (clk),
        .SC_POINT_ROW_SEQUENCER_RESET_InLow       (rst_n),
        .SC_POINT_ROW_SEQUENCER_start_InLow       (start_n),
        .SC_POINT_ROW_SEQUENCER_direction_In      (dir),
        .SC_POINT_ROW_SEQUENCER_collision_In      (col),
        .SC_POINT_ROW_SEQUENCER_levelup_In        (lvl),
        .SC_POINT_ROW_SEQUENCER_clear_OutLow      (clear_n),
        .SC_POINT_ROW_SEQUENCER_load0_OutLow      (load0_n),
        .SC_POINT_ROW_SEQUENCER_load1_OutLow      (load1_n),
        .SC_POINT_ROW_SEQUENCER_shiftselection_Out(shift_sel),
        .SC_POINT_ROW_SEQUENCER_clearLOST_OutLow  (clear_lost_n),
        .SC_POINT_ROW_SEQUENCER_level_OutBUS      (level_o),
        .SC_POINT_ROW_SEQUENCER_lives_OutBUS      (lives_o),
        .SC_POINT_ROW_SEQUENCER_gameover_Out      (gameover)
    );

    // ---------------- reference model (game phases) ----------------
    typedef enum int {G_IDLE, G_CLEAR, G_LOAD0, G_RUN, G_SHIFT, G_LOST, G_LOAD1, G_OVER} phase_t;
    phase_t ph;
    int lives_m, level_m, run_cnt;
    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    function automatic int period_of(int lv);
        int p;
        p = SP / (1 << lv);
        return (p < 1) ? 1 : p;
    endfunction

    function automatic logic [12:0] obs_out();
        return {clear_n, load0_n, load1_n, clear_lost_n, shift_sel, level_o, lives_o, gameover};
    endfunction

    function automatic logic [12:0] idle_out();
        int lv;
        logic [1:0] l2;
        lv = LIVES_EN ? 3 : 0;
        l2 = lv[1:0];
        return {4'b1111, 2'b00, 3'd0, l2, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %b want %b (clr,ld0,ld1,lost,shift,level,lives,go)", tag, got, want);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        ph      = G_IDLE;
        lives_m = LIVES_EN ? 3 : 0;
        level_m = 0;
        run_cnt = 0;
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs, predicts the outputs that follow the edge.
    task automatic step(input bit s, input bit d, input bit c, input bit l, input string tag);
        logic [3:0] cmd;
        logic [1:0] sh;
        logic       go;
        logic [2:0] lv3;
        logic [1:0] li2;
        start_n = s; dir = d; col = c; lvl = l;
        cmd = {ph != G_CLEAR, ph != G_LOAD0, ph != G_LOAD1, ph != G_LOST};
        sh  = (ph == G_SHIFT) ? (d ? 2'b10 : 2'b01) : 2'b00;
        go  = (ph == G_OVER);
        case (ph)
            G_IDLE:  if (!s) ph = G_CLEAR;
            G_CLEAR: ph = G_LOAD0;
            G_LOAD0: ph = G_RUN;
            G_RUN: begin
                if (c) begin
                    ph = G_LOST; run_cnt = 0;
                end else if (l) begin
                    ph = G_LOAD1; run_cnt = 0;
                end else begin
                    run_cnt++;
                    if (run_cnt == period_of(level_m)) begin
                        run_cnt = 0; ph = G_SHIFT;
                    end
                end
            end
            G_SHIFT: ph = G_RUN;
            G_LOST: begin
                if (LIVES_EN) begin
                    lives_m--;
                    ph = (lives_m > 0) ? G_LOAD0 : G_OVER;
                end else begin
                    ph = G_OVER;
                end
            end
            G_LOAD1: begin
                if (level_m < 7) level_m++;
                ph = G_RUN;
            end
            G_OVER: if (!s) begin
                ph = G_CLEAR; lives_m = LIVES_EN ? 3 : 0; level_m = 0;
            end
            default: ph = G_IDLE;
        endcase
        lv3 = level_m[2:0];
        li2 = lives_m[1:0];
        exp_q.push_back({cmd, sh, lv3, li2, go});
        @(posedge clk);
        #1;
        check(tag, obs_out(), exp_q.pop_front());
    endtask

    task automatic ensure_run();
        for (int i = 0; i < 30; i++) begin
            if (ph == G_RUN) break;
            step((ph == G_IDLE || ph == G_OVER) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, "to_run");
        end
        check_int("reach_run", int'(ph == G_RUN), 1);
    endtask

    // ---------------- directed sequence + random play ----------------
    initial begin
        int shifts;
        int last_idx;
        bit found;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check("reset_state", obs_out(), idle_out());
        @(posedge clk); #1 rst_n = 1'b1;

        repeat (3) step(1, 0, 0, 0, "idle_hold");
        step(0, 0, 0, 0, "start_low");
        step(1, 0, 0, 0, "clear_pulse");
        check_int("clear_low", int'(clear_n), 0);
        step(1, 0, 0, 0, "load0_pulse");
        check_int("load0_low", int'(load0_n), 0);

        // Level 0 shifting: one left shift per 9 cycles
        shifts = 0; last_idx = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1, 0, 0, 0, "run_l0");
            if (shift_sel == 2'b01) begin
                if (last_idx >= 0) check_int("shift_gap", i - last_idx, 9);
                last_idx = i;
                shifts++;
            end
        end
        check_int("shift_count_l0", shifts, 4);

        // Collision and levelup together: only the loss is honoured
        ensure_run();
        step(1, 0, 1, 1, "col_and_lvl");
        step(1, 0, 0, 0, "lost_pulse");
        check_int("lost_low", int'(clear_lost_n), 0);
        check_int("lost_no_load1", int'(load1_n), 1);
        check_int("lives_after_hit", int'(lives_o), LIVES_EN ? 2 : 0);
        step(1, 0, 0, 0, "after_lost");

        // Keep colliding until game over, then restart
        for (int k = 0; k < 6 && ph != G_OVER; k++) begin
            ensure_run();
            step(1, 1, 1, 0, "hit");
            step(1, 0, 0, 0, "hit_lost");
        end
        step(1, 0, 1, 1, "over_ignore");
        check_int("gameover_high", int'(gameover), 1);
        check_int("lives_zero", int'(lives_o), 0);
        step(0, 0, 0, 0, "restart");
        check_int("restart_lives", int'(lives_o), LIVES_EN ? 3 : 0);
        check_int("restart_level", int'(level_o), 0);
        step(1, 0, 0, 0, "restart_clear");
        check_int("restart_clear_low", int'(clear_n), 0);

        // Three levelups: period 8 >> 3 = 1, shift on every run cycle
        for (int k = 0; k < 3; k++) begin
            ensure_run();
            step(1, 0, 0, 1, "levelup");
            step(1, 0, 0, 0, "load1_pulse");
            check_int("load1_low", int'(load1_n), 0);
        end
        check_int("level_three", int'(level_o), 3);
        ensure_run();
        shifts = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, "run_l3");
            if (shift_sel == 2'b10) shifts++;
        end
        check_int("shift_count_l3", shifts, 5);

        // Saturation at level 7
        for (int k = 0; k < 6; k++) begin
            ensure_run();
            step(1, 0, 0, 1, "levelup_sat");
            step(1, 0, 0, 0, "load1_sat");
        end
        check_int("level_sat", int'(level_o), 7);

        // Random play
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0), "random");
        end

        // Reset while a shift command is on the outputs
        ensure_run();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1, $urandom_range(0, 1) == 1, 0, 0, "seek_shift");
            if (shift_sel != 2'b00) found = 1'b1;
        end
        check_int("shift_seen", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_in_shift", obs_out(), idle_out());
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) step(1, 0, 1, 1, "idle_after_reset");
        step(0, 0, 0, 0, "start_again");
        step(1, 0, 0, 0, "clear_again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
